// File: rtl/bram_pkg.sv
// Shared definitions for the true-dual-port block RAM: read-mode names and controller states.
package bram_pkg;

  // Read-mode selectors, wide enough for the longest name
  typedef logic [8*11-1:0] read_mode_t;

  localparam read_mode_t RM_READ_FIRST  = "READ_FIRST";
  localparam read_mode_t RM_WRITE_FIRST = "WRITE_FIRST";
  localparam read_mode_t RM_NO_CHANGE   = "NO_CHANGE";

  // Controller: CLEAR zero-fills the array, READY serves both ports
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/bram_out_stage.sv
// Optional output pipeline stage for one RAM port: data + valid register or a wire.
module bram_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit OUTPUT_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  if (OUTPUT_REG) begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Extra stage; data only moves on a valid result so it holds otherwise
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) data_q <= in_data;
      end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
  end else begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_data       = in_data;
    assign out_valid      = in_valid;
  end

endmodule

// File: rtl/bram_sync_tdp.sv
// True-dual-port synchronous RAM with byte enables, selectable read mode,
// optional output register and a power-on zero-fill sequence.
module bram_sync_tdp
  import bram_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 4,
  parameter int         BYTE_WIDTH     = 8,
  parameter read_mode_t READ_MODE      = RM_READ_FIRST,
  parameter bit         OUTPUT_REG     = 1'b0,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  localparam int        NB             = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  a_en,
  input  logic [NB-1:0]         a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [NB-1:0]         b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit IS_WF = (READ_MODE == RM_WRITE_FIRST);
  localparam bit IS_NC = (READ_MODE == RM_NO_CHANGE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ctrl_state_t           state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  init_done_q;

  logic                  a_acc, b_acc, a_wr, b_wr, clear_we;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new;
  logic                  a_ret, b_ret;
  logic [DATA_WIDTH-1:0] a_d1_q, b_d1_q;
  logic                  a_v1_q, b_v1_q, collision_q;

  // Controller: walk the clear counter through every address, then go live
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (!CLEAR_ON_RESET || clr_cnt_q == '1) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
        READY:   state_q <= READY;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign init_done = init_done_q;
  assign clear_we  = (state_q == CLEAR) && CLEAR_ON_RESET && !rst;
  assign a_acc     = (state_q == READY) && a_en;
  assign b_acc     = (state_q == READY) && b_en;
  assign a_wr      = |a_we;
  assign b_wr      = |b_we;

  // Array write: clear fill, then B lanes, then A lanes so A wins shared lanes
  always_ff @(posedge clk) begin
    if (clear_we) mem[clr_cnt_q] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (b_acc && b_we[i]) mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (a_acc && a_we[i]) mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Old words and each port's own lane merge (the WRITE_FIRST return value)
  always_comb begin
    a_old = mem[a_addr];
    b_old = mem[b_addr];
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) a_new[i*BYTE_WIDTH +: BYTE_WIDTH] = a_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (b_we[i]) b_new[i*BYTE_WIDTH +: BYTE_WIDTH] = b_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign a_ret = a_acc && !(IS_NC && a_wr);
  assign b_ret = b_acc && !(IS_NC && b_wr);

  // First read stage and collision flag; data registers hold when nothing returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d1_q      <= '0;
      b_d1_q      <= '0;
      a_v1_q      <= 1'b0;
      b_v1_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      a_v1_q      <= a_ret;
      b_v1_q      <= b_ret;
      collision_q <= a_acc && b_acc && (a_addr == b_addr) && (a_wr || b_wr);
      if (a_ret) a_d1_q <= (IS_WF && a_wr) ? a_new : a_old;
      if (b_ret) b_d1_q <= (IS_WF && b_wr) ? b_new : b_old;
    end
  end

  assign collision = collision_q;

  bram_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUTPUT_REG(OUTPUT_REG)
  ) u_out_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (a_d1_q),
    .in_valid (a_v1_q),
    .out_data (a_dout),
    .out_valid(a_valid)
  );

  bram_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUTPUT_REG(OUTPUT_REG)
  ) u_out_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_d1_q),
    .in_valid (b_v1_q),
    .out_data (b_dout),
    .out_valid(b_valid)
  );

endmodule

// File: doc/bram_sync_tdp.md
BRAM_SYNC_TDP -- requirements
Module: bram_sync_tdp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: lane width; DATA_WIDTH must be a multiple of it; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 SHALL have parameter READ_MODE, default "READ_FIRST": one of READ_FIRST, WRITE_FIRST, NO_CHANGE.
REQ-005 SHALL have parameter OUTPUT_REG, default 0: 1 adds one output pipeline stage.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills memory after reset.
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-009 SHALL have ports: init_done  out  1  high once the clear sequence has finished and ports are live.
REQ-010 SHALL have ports: a_en  in  1  port A access request.
REQ-011 SHALL have ports: a_we  in  NB  port A per-byte write enables.
REQ-012 SHALL have ports: a_addr  in  ADDR_WIDTH  port A address.
REQ-013 SHALL have ports: a_din  in  DATA_WIDTH  port A write data.
REQ-014 SHALL have ports: a_dout  out  DATA_WIDTH  port A read data.
REQ-015 SHALL have ports: a_valid  out  1  a_dout is new this cycle.
REQ-016 SHALL have ports: b_en, b_we, b_addr, b_din, b_dout, b_valid, identical to the port A ports, for port B.
REQ-017 SHALL have ports: collision  out  1  address-conflict pulse.

Function
REQ-018 SHALL implement a controller FSM with two states: CLEAR -> READY after address 2**ADDR_WIDTH-1 is written; with CLEAR_ON_RESET=0 it enters READY on the first clock after reset release.
REQ-019 In CLEAR, the block SHALL write zero to one address per cycle, ascending from 0, and ignore a_en/b_en; init_done=0 and both valid outputs stay 0.
REQ-020 An access SHALL be accepted when in READY and x_en=1; it is a write when any x_we bit is 1, otherwise a read.
REQ-021 A write SHALL update only the byte lanes whose x_we bit is 1.
REQ-022 Read latency SHALL be 1+OUTPUT_REG cycles from acceptance to x_valid=1 with x_dout set; x_valid is a single-cycle pulse per access.
REQ-023 READ_FIRST: on a write access, x_dout SHALL return the old word and x_valid SHALL pulse.
REQ-024 WRITE_FIRST: on a write access, x_dout SHALL return the merged new word and x_valid SHALL pulse.
REQ-025 NO_CHANGE: on a write access, x_dout SHALL hold its value and x_valid SHALL not pulse.
REQ-026 x_dout SHALL hold its last value when no new result is due.
REQ-027 When both ports access the same address and at least one writes, then:
- port A SHALL win each byte lane both ports write;
- a port reading a lane written by the other port SHALL get the old data;
- collision SHALL pulse 1 cycle after the access, independent of OUTPUT_REG.
REQ-028 Back-to-back accesses SHALL be accepted every cycle on both ports (throughput 1/cycle/port).

Reset
REQ-029 While rst=1, asynchronously: the FSM SHALL go to CLEAR; init_done, a_valid, b_valid and collision SHALL be 0; a_dout and b_dout SHALL be zero; the clear counter SHALL be 0.
REQ-030 Reset mid-operation SHALL discard in-flight pipeline results; memory contents SHALL not be reset asynchronously, only rewritten by CLEAR.

Structure
REQ-031 A shared package bram_pkg SHALL hold the READ_MODE string constants and the FSM state typedef (CLEAR, READY).
REQ-032 The optional output stage SHALL be a sub-module bram_out_stage (data + valid register, bypassed when OUTPUT_REG=0), instantiated once per port.

Verification
REQ-033 The bench SHALL cover, with DATA_WIDTH=32 and ADDR_WIDTH=4:
- Reset release, CLEAR_ON_RESET=1 -> init_done rises after exactly 16 cycles; reads of addresses 0..15 return 0x00000000.
- OUTPUT_REG=0, READ_FIRST, addr 3 holds 0x11223344; A writes 0xAABBCCDD with a_we=0b0101 -> a_dout=0x11223344 one cycle later; a following read returns 0x11BB33DD.
- WRITE_FIRST, OUTPUT_REG=1, write 0xDEADBEEF to addr 5 -> a_valid and a_dout=0xDEADBEEF two cycles later.
- Same cycle, A writes 0x1 and B writes 0x2 to addr 7, all lanes -> collision=1 next cycle; addr 7 reads 0x00000001.
- NO_CHANGE, read 0xCAFE0000 then write at another address -> a_dout stays 0xCAFE0000 with no a_valid pulse on the write.
- rst asserted mid-stream with reads in flight -> outputs zero immediately, no stale a_valid; init_done returns after 16 cycles.
